// File: rtl/clk_div_mon_pkg.sv
// Shared definitions for the divided-clock period monitor: FSM states and
// default monitoring constants.
package clk_div_mon_pkg;

  localparam int DEF_DIVIDE_RATE   = 125;
  localparam int DEF_COUNTER_WIDTH = 8;
  localparam int DEF_TOLERANCE     = 1;
  localparam int DEF_LOCK_COUNT    = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clk_div_monitor.sv
// Measures the period of an asynchronous divided clock in clk_i cycles and
// tracks lock against DIVIDE_RATE +/- TOLERANCE, with a sticky loss flag.
module clk_div_monitor
  import clk_div_mon_pkg::*;
#(
  parameter int DIVIDE_RATE   = DEF_DIVIDE_RATE,
  parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH,
  parameter int TOLERANCE     = DEF_TOLERANCE,
  parameter int LOCK_COUNT    = DEF_LOCK_COUNT
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clk_div_i,
  input  logic                     clr_i,
  output logic [COUNTER_WIDTH-1:0] period_o,
  output logic                     period_valid_o,
  output logic                     locked_o,
  output logic                     lost_o,
  output logic [1:0]               state_o
);

  localparam int MC_W = $clog2(LOCK_COUNT + 1);
  localparam int LO   = (DIVIDE_RATE > TOLERANCE) ? (DIVIDE_RATE - TOLERANCE) : 0;
  localparam int HI   = DIVIDE_RATE + TOLERANCE;

  localparam logic [COUNTER_WIDTH-1:0] SAT_C  = COUNTER_WIDTH'(2 * DIVIDE_RATE);
  localparam logic [COUNTER_WIDTH-1:0] ONE_C  = COUNTER_WIDTH'(1);
  localparam logic [COUNTER_WIDTH:0]   LO_C   = (COUNTER_WIDTH + 1)'(LO);
  localparam logic [COUNTER_WIDTH:0]   HI_C   = (COUNTER_WIDTH + 1)'(HI);
  localparam logic [MC_W-1:0]          LOCK_C = MC_W'(LOCK_COUNT);
  localparam logic [MC_W-1:0]          MC_ONE = MC_W'(1);

  logic                     sync2_q;
  logic                     sync3_q;
  logic                     edge_det;
  logic [COUNTER_WIDTH-1:0] cnt_q;
  logic                     timeout;
  logic                     in_tol;

  state_t                   state_q, state_d;
  logic [MC_W-1:0]          match_q, match_d, match_inc;
  logic [COUNTER_WIDTH-1:0] period_q, period_d;
  logic                     valid_q, valid_d;
  logic                     locked_q, locked_d;
  logic                     lost_q, lost_d, lost_set;

  sync_2ff u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d     (clk_div_i),
    .q     (sync2_q)
  );

  assign edge_det  = sync2_q & ~sync3_q;
  assign timeout   = (cnt_q == SAT_C);
  // Zero-extended compares keep the window check free of unsigned wrap.
  assign in_tol    = ({1'b0, cnt_q} >= LO_C) && ({1'b0, cnt_q} <= HI_C);
  assign match_inc = match_q + MC_ONE;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync3_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync3_q <= sync2_q;
      if (edge_det)
        cnt_q <= ONE_C;
      else if (cnt_q != SAT_C)
        cnt_q <= cnt_q + ONE_C;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      match_q  <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      match_q  <= match_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      lost_q   <= lost_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    match_d  = match_q;
    period_d = period_q;
    valid_d  = 1'b0;
    lost_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // First edge only starts a clean measurement window.
        if (edge_det) begin
          state_d = ST_MEASURE;
          match_d = '0;
        end
      end
      ST_MEASURE, ST_LOCKED: begin
        if (timeout) begin
          state_d  = ST_IDLE;
          match_d  = '0;
          lost_set = 1'b1;
        end else if (edge_det) begin
          period_d = cnt_q;
          valid_d  = 1'b1;
          if (in_tol) begin
            if (state_q == ST_MEASURE) begin
              match_d = (match_q < LOCK_C) ? match_inc : LOCK_C;
              if (match_d == LOCK_C)
                state_d = ST_LOCKED;
            end
          end else begin
            match_d = '0;
            state_d = ST_MEASURE;
            if (state_q == ST_LOCKED)
              lost_set = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        match_d = '0;
      end
    endcase
    locked_d = (state_d == ST_LOCKED);
    lost_d   = lost_set | (lost_q & ~clr_i);
  end

  assign period_o       = period_q;
  assign period_valid_o = valid_q;
  assign locked_o       = locked_q;
  assign lost_o         = lost_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: expected pulses are queued as each
// divided-clock edge is driven and compared when period_valid_o fires.
module tb_clk_div_monitor;

  logic       clk;
  logic       rst;
  logic       clk_div;
  logic       clr;
  logic [7:0] period;
  logic       period_valid;
  logic       locked;
  logic       lost;
  logic [1:0] dbg_state;

  int checks   = 0;
  int failures = 0;
  int prev_p   = 0;

  // {period, locked, lost}
  logic [9:0] exp_q[$];
  logic [9:0] exp_item;

  clk_div_monitor #(
    .DIVIDE_RATE   (125),
    .COUNTER_WIDTH (8),
    .TOLERANCE     (1),
    .LOCK_COUNT    (4)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .clk_div_i      (clk_div),
    .clr_i          (clr),
    .period_o       (period),
    .period_valid_o (period_valid),
    .locked_o       (locked),
    .lost_o         (lost),
    .state_o        (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Driver: one divided-clock period of p cycles starting with a rising edge.
  // The pulse for that edge reports the previous period (prev_p).
  task automatic run_period(input int p, input bit pulse, input bit e_lock, input bit e_lost);
    if (pulse) exp_q.push_back({8'(prev_p), e_lock, e_lost});
    clk_div = 1'b1;
    repeat (p / 2) @(negedge clk);
    clk_div = 1'b0;
    repeat (p - p / 2) @(negedge clk);
    prev_p = p;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
    prev_p = prev_p + n;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_period"}, 32'(period), 0);
    check({tag, "_valid"},  32'(period_valid), 0);
    check({tag, "_locked"}, 32'(locked), 0);
    check({tag, "_lost"},   32'(lost), 0);
    check({tag, "_state"},  32'(dbg_state), 0);
  endtask

  // Scoreboard
  always @(negedge clk) begin
    if (!rst && period_valid) begin
      checks++;
      assert (exp_q.size() > 0)
      else begin
        failures++;
        $error("FAIL unexpected_pulse observed=pulse period %0d expected=no pulse", period);
      end
      if (exp_q.size() > 0) begin
        exp_item = exp_q.pop_front();
        check("pulse_period", 32'(period), 32'(exp_item[9:2]));
        check("pulse_locked", 32'(locked), 32'(exp_item[1]));
        check("pulse_lost",   32'(lost),   32'(exp_item[0]));
      end
    end
  end

  initial begin
    clk_div = 1'b0;
    clr     = 1'b0;
    rst     = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Clean lock: first edge discarded, lock on the 4th pulse
    run_period(125, 0, 0, 0);
    for (int i = 0; i < 4; i++) run_period(125, 1, (i == 3), 0);
    check("a_locked", 32'(locked), 1);
    check("a_lost", 32'(lost), 0);

    // One long period breaks lock, four good periods relock
    run_period(127, 1, 1, 0);
    run_period(125, 1, 0, 1);
    for (int i = 0; i < 4; i++) run_period(125, 1, (i == 3), 1);
    check("b_relocked", 32'(locked), 1);
    check("b_lost_sticky", 32'(lost), 1);
    clr = 1'b1;
    idle_cycles(1);
    clr = 1'b0;
    check("b_clr_lost", 32'(lost), 0);

    // Divided clock stops: timeout after 2*DIVIDE_RATE cycles
    run_period(125, 1, 1, 0);
    repeat (115) @(negedge clk);
    check("d_still_locked", 32'(locked), 1);
    repeat (16) @(negedge clk);
    check("d_timeout_locked", 32'(locked), 0);
    check("d_timeout_lost", 32'(lost), 1);
    check("d_timeout_state", 32'(dbg_state), 0);
    run_period(125, 0, 0, 1);
    for (int i = 0; i < 4; i++) run_period(125, 1, (i == 3), 1);
    check("d_relocked", 32'(locked), 1);
    clr = 1'b1;
    idle_cycles(1);
    clr = 1'b0;
    check("d_clr_lost", 32'(lost), 0);

    // Jitter inside the tolerance window keeps lock
    for (int i = 0; i < 8; i++) run_period((i % 2) ? 126 : 124, 1, 1, 0);
    check("c_locked", 32'(locked), 1);

    // clr coincident with the timeout: set wins
    run_period(125, 1, 1, 0);
    repeat (127) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("e_set_wins_lost", 32'(lost), 1);
    check("e_timeout_locked", 32'(locked), 0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("e_clr_alone", 32'(lost), 0);

    // Asynchronous reset mid-cycle while locked
    run_period(125, 0, 0, 0);
    for (int i = 0; i < 4; i++) run_period(125, 1, (i == 3), 0);
    check("f_locked_before", 32'(locked), 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_all_zero("async_reset");
    repeat (3) @(posedge clk);
    #4 rst = 1'b0;
    @(negedge clk);
    run_period(125, 0, 0, 0);
    for (int i = 0; i < 4; i++) run_period(125, 1, (i == 3), 0);
    check("f_relocked", 32'(locked), 1);
    check("f_lost", 32'(lost), 0);

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
